// File: rtl/fifo_width_up.sv
// rtl/fifo_width_up.sv - packs RATIO narrow FIFO words into one wide word (optional EOP flush: FIFO_WIDTH_UP_EOP_EN)
module fifo_width_up #(
    parameter int IN_BITS  = 8,
    parameter int RATIO    = 4,
    parameter int OUT_BITS = IN_BITS * RATIO,
    parameter int CBITS    = $clog2(RATIO)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_val,
    input  logic [IN_BITS-1:0]  i_dat,
    input  logic                i_eop,
    output logic                o_rdy,
    output logic                o_val,
    output logic [OUT_BITS-1:0] o_dat,
    output logic                o_eop,
    output logic [CBITS:0]      o_mod,
    input  logic                i_rdy
);

    // Lane count of words held in the pack register, and the pack register
    // itself. The top lane of pack is never written: the word that fills it
    // goes straight into the output register.
    logic [CBITS-1:0]    cnt;
    logic [OUT_BITS-1:0] pack;
    logic [OUT_BITS-1:0] next_word;
    logic [CBITS:0]      next_mod;
    logic                eop_in;
    logic                last_lane;
    logic                in_xfer;
    logic                out_xfer;
    logic                complete;

`ifdef FIFO_WIDTH_UP_EOP_EN
    assign eop_in = i_eop;
`else
    // End-of-packet has no effect in this build; the input is folded away.
    assign eop_in = 1'b0 & i_eop;
`endif

    assign last_lane = (cnt == CBITS'(RATIO - 1));

    // Non-completing words are always taken; a completing word only waits
    // when the output register is full and not draining this cycle.
    assign o_rdy    = (!last_lane && !eop_in) || !o_val || i_rdy;
    assign in_xfer  = i_val && o_rdy;
    assign out_xfer = o_val && i_rdy;
    assign complete = in_xfer && (last_lane || eop_in);

    // Pack register with the incoming word dropped into the current lane.
    // Lanes above cnt are always zero, so a short (flushed) word comes out
    // with its unused upper lanes already cleared.
    always_comb begin
        next_word = pack;
        next_word[int'(cnt) * IN_BITS +: IN_BITS] = i_dat;
        next_mod  = {1'b0, cnt} + {{CBITS{1'b0}}, 1'b1};
    end

    // Lane accumulation: append narrow words, restart at lane 0 on completion.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt  <= '0;
            pack <= '0;
        end else if (complete) begin
            cnt  <= '0;
            pack <= '0;
        end else if (in_xfer) begin
            cnt  <= cnt + 1'b1;
            pack <= next_word;
        end
    end

    // Output register: load on completion (even while draining, so there is
    // no bubble), release on a transfer with nothing new, otherwise hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_val <= 1'b0;
            o_dat <= '0;
            o_eop <= 1'b0;
            o_mod <= '0;
        end else if (complete) begin
            o_val <= 1'b1;
            o_dat <= next_word;
            o_eop <= eop_in;
            o_mod <= next_mod;
        end else if (out_xfer) begin
            o_val <= 1'b0;
        end
    end

endmodule

// File: doc/fifo_width_up.md
Name: fifo_width_up

Overview:
- Downstream consumer of the CDC FIFO read side: packs RATIO consecutive narrow words from the FIFO's valid/ready output into one wide word for the wide datapath.
- Single clock domain: the FIFO's read clock.
- Full-throughput: one narrow word accepted per cycle with no bubbles, including at word boundaries.
- Optional end-of-packet flush of partially filled wide words.

Parameters:
- IN_BITS, 8, width of one narrow input word.
- RATIO, 4, narrow words per wide word; must be a power of 2 and >= 2.
- OUT_BITS, IN_BITS*RATIO, wide output width. Derived; do not override.
- CBITS, $clog2(RATIO), lane counter width. Derived.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_val  in  1  narrow word valid (from FIFO o_val_b).
- i_dat  in  IN_BITS  narrow word (from FIFO o_dat_b).
- i_eop  in  1  last narrow word of packet; used only with the feature enabled.
- o_rdy  out  1  ready to accept narrow word (to FIFO i_rdy_b).
- o_val  out  1  wide word valid.
- o_dat  out  OUT_BITS  wide word.
- o_eop  out  1  wide word closes a packet.
- o_mod  out  CBITS+1  number of valid lanes in o_dat, 1..RATIO.
- i_rdy  in  1  downstream ready for wide word.

Behaviour:
- Reset (i_rst_n=0, async): o_val=0, o_dat=0, o_eop=0, o_mod=0, lane count=0, pack register=0. Partial data in flight is discarded.
- Handshakes:
  - Transfer on input when i_val&&o_rdy. Transfer on output when o_val&&i_rdy.
  - o_val/o_dat/o_eop/o_mod hold stable while o_val&&!i_rdy.
- Lane order:
  - First accepted word goes to lane 0 (o_dat[IN_BITS-1:0]); lane k is o_dat[k*IN_BITS +: IN_BITS].
  - Lanes 0..RATIO-2 are held in the pack register. cnt counts held lanes, 0..RATIO-1, wrapping to 0.
- Word completion:
  - Trigger: input transfer when cnt==RATIO-1 (or a flush, see Optional Feature).
  - Next edge: o_dat <= {i_dat, pack lanes}; o_val=1; o_mod=RATIO; cnt=0; pack register cleared to 0.
  - Latency: o_val rises the cycle after the completing input transfer.
- Ready rule:
  - o_rdy = (cnt!=RATIO-1) || !o_val || i_rdy, combinational.
  - Non-completing words are always accepted, even while output is stalled.
  - The completing word waits only if the output register is occupied and not draining.
- Simultaneous events:
  - Output transfer and completion on the same edge: o_val stays 1 and new data is loaded. No bubble.
  - Output transfer without completion: o_val <= 0.
- Sustained i_val=1, i_rdy=1: one wide word every RATIO cycles, o_rdy constantly 1.
- Backpressure: if i_rdy is held 0, at most RATIO-1 further narrow words are accepted after o_val rises. Then o_rdy=0.
- Idle: o_val=0 does not affect pack contents. Partial words wait indefinitely (feature disabled).

Optional Feature:
- Macro: FIFO_WIDTH_UP_EOP_EN.
- With the macro defined:
  - An input transfer with i_eop=1 completes the wide word regardless of cnt.
  - Output: lanes above the eop lane are zero, o_mod=cnt+1, o_eop=1, cnt=0.
  - Ready rule becomes o_rdy = (cnt!=RATIO-1 && !i_eop) || !o_val || i_rdy.
  - A full word completed by i_eop has o_eop=1, o_mod=RATIO.
- Without the macro:
  - i_eop is ignored. o_eop is tied 0. o_mod is always RATIO when o_val=1.

Test Plan:
- IN_BITS=8, RATIO=4, i_rdy=1; input 0x11,0x22,0x33,0x44 on consecutive cycles -> o_dat=0x44332211 one cycle after 0x44, o_mod=4, o_eop=0, o_rdy stays 1.
- Streaming 0x00..0x0F back-to-back, i_rdy=1 -> four wide words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, spaced exactly 4 cycles, no gaps.
- First word pending with i_rdy=0; feed 0x55,0x66,0x77,0x88 -> first three accepted, o_rdy=0 on 0x88. Raise i_rdy -> old word transfers, 0x88776655 loaded same edge, o_val never drops.
- Assert i_rst_n=0 mid-word after 0xAA,0xBB, release, feed 0x01..0x04 -> o_dat=0x04030201; no trace of 0xAA/0xBB; outputs 0 during reset.
- With FIFO_WIDTH_UP_EOP_EN: 0xA1, 0xA2 with i_eop=1 on 0xA2 -> o_dat=0x0000A2A1, o_mod=2, o_eop=1. Next words start at lane 0.
- Without the macro, the same stimulus as the previous test -> no output until two more words (0xB1,0xB2) arrive -> o_dat=0xB2B1A2A1, o_eop=0.
